cdc_bridge: RTL and testbench
=============================

// Module: cdc_bridge
// PURPOSE
//  Register-access bridge between a processor-side port and an asynchronous
//  peripheral/memory side (e.g. FIR coefficient RAM on its own clock).
//  Registers outgoing address/data/write strobe in the clk_a domain and
//  safely synchronises the asynchronous read-back bus into clk_a.
//  Interface: one clock (clk_a); reset is asynchronous and active-low (rst_n).
//  Consumer must sample CDC_* with a clock at least as fast as clk_a.
// PARAMETERS
//  ADDR_W       6   address width
//  DATA_W       16  data width
//  SYNC_STAGES  2   flops in data_back synchroniser (>=2)
//  WR_PULSE     1   clk_a cycles CDC_wr stays high per write (>=1)
// PORTS
//  clk_a        in   1       sole clock
//  rst_n        in   1       async active-low reset
//  p_address    in   ADDR_W  processor address (read and write)
//  p_data       in   DATA_W  processor write data
//  p_wr         in   1       write request, sampled each rising clk_a
//  p_data_back  out  DATA_W  synchronised read-back data
//  CDC_A        out  ADDR_W  registered address to far side
//  CDC_data     out  DATA_W  registered write data to far side
//  CDC_wr       out  1       registered write strobe to far side
//  data_back    in   DATA_W  read data from far side, asynchronous to clk_a
// BEHAVIOUR
//  - Reset (rst_n=0, async): CDC_A=0, CDC_data=0, CDC_wr=0, p_data_back=0,
//    all synchroniser/filter flops and pulse counter cleared; no write issued.
//  - Write: p_wr=1 at edge N -> at edge N, CDC_A<=p_address, CDC_data<=p_data,
//    CDC_wr<=1; CDC_wr stays 1 for exactly WR_PULSE cycles then 0.
//    CDC_A/CDC_data held constant for the whole pulse and one cycle after.
//  - p_wr=1 while pulse active: restart pulse with new addr/data (last wins).
//  - p_wr held high for k cycles: k back-to-back captures, CDC_wr high
//    continuously.
//  - Idle (no pulse, not in post-pulse hold): CDC_A<=p_address every cycle
//    (1-cycle latency); CDC_data keeps last written value.
//  - Read-back: data_back -> SYNC_STAGES flop chain -> stability filter:
//    p_data_back updates only when the last two synchroniser outputs are
//    equal; otherwise it holds. Latency from stable data_back to p_data_back:
//    SYNC_STAGES+1 clk_a cycles (3 by default).
//  - Read sequence: p_address change -> CDC_A next cycle -> far side responds
//    -> valid p_data_back no later than 8 clk_a cycles after p_address set.
//  - No combinational path input->output; every output is a flop.
//  - Reset mid-write aborts pulse immediately (CDC_wr=0 asynchronously).
// TESTING  (clk_a 20 ns; far-side model: 64x16 RAM on 14 ns async clock,
//  writes mem[CDC_A]<=CDC_data when CDC_wr, data_back<=mem[CDC_A] each edge)
//  - Reset: rst_n=0 50 ns -> all outputs 0, no RAM write logged.
//  - Writes (1,0x1111),(5,0xABCD),(10,0x1234),(32,0xDEAD),(63,0xBEEF), 1-cycle
//    p_wr each -> each RAM word written with exact value, CDC_wr high 1 cycle.
//  - Reads of addresses 1,5,10,32,63 -> p_data_back = 0x1111,0xABCD,0x1234,
//    0xDEAD,0xBEEF within 10 clk_a cycles of p_address.
//  - p_wr held 2 cycles: (2,0x0002) then (3,0x0003) -> both RAM words written.
//  - data_back toggled every clk_a cycle -> p_data_back holds, never shows a
//    value not present on data_back.
//  - rst_n low during CDC_wr=1 -> CDC_wr drops without waiting for clk_a edge.

Source files
------------

// File: rtl/cdc_bridge.sv
`default_nettype none
// ============================================================================
// Module      : cdc_bridge
// Description : Register-access bridge between a processor port and a far-side
//               peripheral or memory that runs on its own clock. Outgoing
//               address, data and write strobe are registered in clk_a. The
//               read-back bus is asynchronous to clk_a, so it passes through a
//               flop synchroniser and a stability filter before it is
//               presented to the processor.
// Ports       : clk_a        - sole clock
//               rst_n        - asynchronous active-low reset
//               p_address    - processor address (read and write)
//               p_data       - processor write data
//               p_wr         - write request, sampled every rising clk_a
//               p_data_back  - synchronised, filtered read-back data
//               CDC_A        - registered address to the far side
//               CDC_data     - registered write data to the far side
//               CDC_wr       - registered write strobe, WR_PULSE cycles long
//               data_back    - read data from the far side (async to clk_a)
// Revision    : 1.0 - initial release
// ============================================================================
module cdc_bridge #(
  parameter int ADDR_W      = 6,
  parameter int DATA_W      = 16,
  parameter int SYNC_STAGES = 2,
  parameter int WR_PULSE    = 1
) (
  input  logic              clk_a,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] p_address,
  input  logic [DATA_W-1:0] p_data,
  input  logic              p_wr,
  output logic [DATA_W-1:0] p_data_back,
  output logic [ADDR_W-1:0] CDC_A,
  output logic [DATA_W-1:0] CDC_data,
  output logic              CDC_wr,
  input  logic [DATA_W-1:0] data_back
);

  // A single-flop synchroniser is never safe, so the chain is at least two deep.
  localparam int STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
  localparam int PULSE  = (WR_PULSE < 1) ? 1 : WR_PULSE;
  localparam int CNT_W  = (PULSE > 1) ? $clog2(PULSE) : 1;
  // Cycles the strobe must still stay high after the capturing cycle.
  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE - 1);

  logic [CNT_W-1:0]  pulse_cnt;
  logic [DATA_W-1:0] sync_q [STAGES];

  // --------------------------------------------------------------------------
  // Write path. A request always wins and (re)starts the pulse. While the
  // strobe is high the address is frozen; the cycle in which the strobe falls
  // is also a non-updating cycle, which gives the one-cycle post-pulse hold
  // without a separate flag. Outside that window the address follows
  // p_address with one cycle of latency so reads need no extra handshake.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_a or negedge rst_n) begin
    if (!rst_n) begin
      CDC_A     <= '0;
      CDC_data  <= '0;
      CDC_wr    <= 1'b0;
      pulse_cnt <= '0;
    end else if (p_wr) begin
      CDC_A     <= p_address;
      CDC_data  <= p_data;
      CDC_wr    <= 1'b1;
      pulse_cnt <= PULSE_LAST;
    end else if (CDC_wr) begin
      if (pulse_cnt == '0) begin
        CDC_wr <= 1'b0;
      end else begin
        pulse_cnt <= pulse_cnt - 1'b1;
      end
    end else begin
      CDC_A <= p_address;
    end
  end

  // --------------------------------------------------------------------------
  // Read-back path. The multi-bit bus is sampled raw, so individual bits may
  // resolve on different cycles while it changes. The output is only updated
  // when the two last synchroniser stages agree, i.e. the bus was seen
  // identical on two consecutive cycles, so a torn word is never presented.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_a or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) begin
        sync_q[i] <= '0;
      end
      p_data_back <= '0;
    end else begin
      sync_q[0] <= data_back;
      for (int i = 1; i < STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      if (sync_q[STAGES-1] == sync_q[STAGES-2]) begin
        p_data_back <= sync_q[STAGES-1];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cdc_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_cdc_bridge
// Description : Self-checking bench for cdc_bridge. A 64x16 RAM on an
//               unrelated 14 ns clock acts as the far side; the expected
//               memory image is kept separately as a plain array updated
//               from each issued write.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cdc_bridge;

  localparam int ADDR_W = 6;
  localparam int DATA_W = 16;

  logic              clk_a;
  logic              clk_b;
  logic              rst_n;
  logic [ADDR_W-1:0] p_address;
  logic [DATA_W-1:0] p_data;
  logic              p_wr;
  logic [DATA_W-1:0] p_data_back;
  logic [ADDR_W-1:0] CDC_A;
  logic [DATA_W-1:0] CDC_data;
  logic              CDC_wr;
  logic [DATA_W-1:0] data_back;

  // far-side RAM model and override for direct data_back stimulus
  logic [DATA_W-1:0] mem [64];
  logic [DATA_W-1:0] ram_q;
  logic              ovr_en;
  logic [DATA_W-1:0] ovr_val;
  int                write_count;

  // expected memory image
  logic [DATA_W-1:0] ref_mem [64];

  int checks;
  int errors;

  assign data_back = ovr_en ? ovr_val : ram_q;

  cdc_bridge #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .SYNC_STAGES(2),
    .WR_PULSE   (1)
  ) dut (
    .clk_a      (clk_a),
    .rst_n      (rst_n),
    .p_address  (p_address),
    .p_data     (p_data),
    .p_wr       (p_wr),
    .p_data_back(p_data_back),
    .CDC_A      (CDC_A),
    .CDC_data   (CDC_data),
    .CDC_wr     (CDC_wr),
    .data_back  (data_back)
  );

  initial begin
    clk_a = 1'b0;
    forever #10 clk_a = ~clk_a;
  end

  initial begin
    clk_b = 1'b0;
    forever #7 clk_b = ~clk_b;
  end

  initial begin
    for (int i = 0; i < 64; i++) begin
      mem[i]     = '0;
      ref_mem[i] = '0;
    end
    ram_q       = '0;
    write_count = 0;
  end

  always @(posedge clk_b) begin
    if (CDC_wr) begin
      mem[CDC_A]  <= CDC_data;
      write_count <= write_count + 1;
    end
    ram_q <= mem[CDC_A];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_a);
    #1;
  endtask

  task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    logic [ADDR_W-1:0] nxt;
    p_address = a;
    p_data    = d;
    p_wr      = 1'b1;
    step();
    check("wr_strobe_high", 32'(CDC_wr), 32'd1);
    check("wr_addr", 32'(CDC_A), 32'(a));
    check("wr_data", 32'(CDC_data), 32'(d));
    p_wr      = 1'b0;
    nxt       = ADDR_W'($urandom);
    p_address = nxt;
    p_data    = DATA_W'($urandom);
    step();
    check("wr_strobe_low", 32'(CDC_wr), 32'd0);
    check("wr_addr_hold", 32'(CDC_A), 32'(a));
    step();
    check("idle_addr_follow", 32'(CDC_A), 32'(nxt));
    check("idle_data_keep", 32'(CDC_data), 32'(d));
    ref_mem[a] = d;
    step();
    check("ram_word", 32'(mem[a]), 32'(ref_mem[a]));
  endtask

  task automatic do_read(input logic [ADDR_W-1:0] a);
    p_address = a;
    for (int i = 0; i < 10; i++) begin
      step();
      if (p_data_back === ref_mem[a]) break;
    end
    check("read_back", 32'(p_data_back), 32'(ref_mem[a]));
  endtask

  initial begin
    logic [ADDR_W-1:0] dir_a [5];
    logic [DATA_W-1:0] dir_d [5];
    logic [ADDR_W-1:0] rnd_a [$];
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] v;
    logic [DATA_W-1:0] x;
    logic [DATA_W-1:0] y;
    int                wc;

    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    p_wr      = 1'b0;
    p_address = '0;
    p_data    = '0;
    ovr_en    = 1'b0;
    ovr_val   = '0;

    // reset state
    #40;
    check("rst_CDC_A", 32'(CDC_A), 32'd0);
    check("rst_CDC_data", 32'(CDC_data), 32'd0);
    check("rst_CDC_wr", 32'(CDC_wr), 32'd0);
    check("rst_p_data_back", 32'(p_data_back), 32'd0);
    check("rst_no_ram_write", 32'(write_count), 32'd0);
    step();
    rst_n = 1'b1;
    step();

    // directed writes then reads
    dir_a = '{6'd1, 6'd5, 6'd10, 6'd32, 6'd63};
    dir_d = '{16'h1111, 16'hABCD, 16'h1234, 16'hDEAD, 16'hBEEF};
    for (int i = 0; i < 5; i++) do_write(dir_a[i], dir_d[i]);
    for (int i = 0; i < 5; i++) do_read(dir_a[i]);

    // p_wr held for two cycles: back-to-back captures, strobe stays high
    wc        = write_count;
    p_address = 6'd2;
    p_data    = 16'h0002;
    p_wr      = 1'b1;
    step();
    check("b2b_first_addr", 32'(CDC_A), 32'd2);
    check("b2b_first_wr", 32'(CDC_wr), 32'd1);
    p_address = 6'd3;
    p_data    = 16'h0003;
    step();
    check("b2b_second_addr", 32'(CDC_A), 32'd3);
    check("b2b_second_data", 32'(CDC_data), 32'h0003);
    check("b2b_second_wr", 32'(CDC_wr), 32'd1);
    p_wr = 1'b0;
    step();
    check("b2b_wr_low", 32'(CDC_wr), 32'd0);
    ref_mem[2] = 16'h0002;
    ref_mem[3] = 16'h0003;
    step();
    check("b2b_ram2", 32'(mem[2]), 32'h0002);
    check("b2b_ram3", 32'(mem[3]), 32'h0003);
    check("b2b_ram_wrote", 32'(write_count > wc), 32'd1);
    do_read(6'd2);
    do_read(6'd3);

    // randomized writes and read-back against the expected image
    for (int i = 0; i < 8; i++) begin
      a = ADDR_W'($urandom_range(0, 63));
      rnd_a.push_back(a);
      do_write(a, DATA_W'($urandom));
    end
    for (int i = 0; i < 8; i++) begin
      do_read(rnd_a[$urandom_range(0, 7)]);
    end

    // randomized idle address tracking (one-cycle latency)
    for (int i = 0; i < 4; i++) begin
      a         = ADDR_W'($urandom);
      p_address = a;
      step();
      check("idle_addr_latency", 32'(CDC_A), 32'(a));
    end

    // data_back toggling every cycle: output must hold the last stable word
    do_read(6'd10);
    v = ref_mem[10];
    x = v ^ 16'h5A5A;
    y = v ^ 16'hA5A5;
    ovr_en = 1'b1;
    for (int i = 0; i < 12; i++) begin
      ovr_val = (i % 2 == 0) ? x : y;
      step();
      check("toggle_hold", 32'(p_data_back), 32'(v));
    end
    ovr_val = x;
    for (int i = 0; i < 6; i++) begin
      step();
      if (p_data_back === x) break;
    end
    check("toggle_settle", 32'(p_data_back), 32'(x));
    ovr_en = 1'b0;
    step();

    // asynchronous reset while the strobe is high
    p_address = 6'd7;
    p_data    = 16'h7777;
    p_wr      = 1'b1;
    step();
    check("arst_wr_before", 32'(CDC_wr), 32'd1);
    p_wr = 1'b0;
    #5;
    rst_n = 1'b0;
    #1;
    check("arst_wr_dropped", 32'(CDC_wr), 32'd0);
    check("arst_CDC_A", 32'(CDC_A), 32'd0);
    check("arst_CDC_data", 32'(CDC_data), 32'd0);
    check("arst_p_data_back", 32'(p_data_back), 32'd0);
    step();
    rst_n = 1'b1;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
